reg_xfer_ctrl: RTL and testbench

- Command-driven sequencer that acts as the client side of the GB80 8-bit register file.
- Accepts register-transfer commands from the decode/control unit over a valid/ready handshake.
- Translates each command into a timed sequence of register-file read/write strobes.
- Absorbs the register file's one-cycle registered read latency, and returns read data for RD commands over a second valid/ready handshake.

---
 rtl/reg_xfer_ctrl.sv | 159 +++++++++++++++
 tb/tb_reg_xfer_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_xfer_ctrl.sv
// reg_xfer_ctrl: command sequencer driving the GB80 register file.
// Turns MOV/LDI/LDI16/RD commands into timed read/write strobes.
module reg_xfer_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 3
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      i_cmd_valid,
  output logic                      o_cmd_ready,
  input  logic [1:0]                i_cmd_op,
  input  logic [ADDRESS_WIDTH-1:0]  i_cmd_dst,
  input  logic [ADDRESS_WIDTH-1:0]  i_cmd_src,
  input  logic [2*DATA_WIDTH-1:0]   i_cmd_imm,
  output logic                      o_rf_wr_en,
  output logic                      o_rf_rd_en,
  output logic [ADDRESS_WIDTH-1:0]  o_rf_addr,
  output logic [DATA_WIDTH-1:0]     o_rf_wdata,
  input  logic [DATA_WIDTH-1:0]     i_rf_rdata,
  output logic                      o_rsp_valid,
  input  logic                      i_rsp_ready,
  output logic [DATA_WIDTH-1:0]     o_rsp_data,
  output logic                      o_done,
  output logic                      o_err
);

  typedef enum logic [2:0] {
    IDLE, RD, RWAIT, WR, WR_HI, WR_LO, RSP
  } state_t;

  localparam logic [1:0] OP_MOV   = 2'd0;
  localparam logic [1:0] OP_LDI   = 2'd1;
  localparam logic [1:0] OP_LDI16 = 2'd2;
  localparam logic [1:0] OP_RD    = 2'd3;

  localparam logic [ADDRESS_WIDTH-1:0] MEM = ADDRESS_WIDTH'(6);

  state_t                     state;
  logic [ADDRESS_WIDTH-1:0]   dst_q;
  logic [DATA_WIDTH-1:0]      imm_q;
  logic                       is_rd;

  // Decode of the command currently on the inputs
  logic dst_mem, src_mem, pair_bad, illegal;
  logic [ADDRESS_WIDTH-1:0] pair_hi, pair_lo;

  // Combinational legality check and LDI16 pair address build
  always_comb begin
    dst_mem  = (i_cmd_dst == MEM);
    src_mem  = (i_cmd_src == MEM);
    pair_bad = (i_cmd_dst[1:0] == 2'd3);
    pair_hi  = ADDRESS_WIDTH'({i_cmd_dst[1:0], 1'b0});
    pair_lo  = ADDRESS_WIDTH'({i_cmd_dst[1:0], 1'b1});
    illegal  = 1'b0;
    case (i_cmd_op)
      OP_MOV:   illegal = dst_mem | src_mem;
      OP_LDI:   illegal = dst_mem;
      OP_LDI16: illegal = pair_bad;
      default:  illegal = src_mem;
    endcase
  end

  // Sequencer FSM with all outputs registered
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= IDLE;
      dst_q       <= '0;
      imm_q       <= '0;
      is_rd       <= 1'b0;
      o_cmd_ready <= 1'b0;
      o_rf_wr_en  <= 1'b0;
      o_rf_rd_en  <= 1'b0;
      o_rf_addr   <= '0;
      o_rf_wdata  <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_data  <= '0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      o_rf_wr_en <= 1'b0;
      o_rf_rd_en <= 1'b0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
      case (state)
        IDLE: begin
          if (o_cmd_ready && i_cmd_valid) begin
            o_cmd_ready <= 1'b0;
            if (illegal) begin
              o_err <= 1'b1;
            end else begin
              case (i_cmd_op)
                OP_MOV, OP_RD: begin
                  o_rf_rd_en <= 1'b1;
                  o_rf_addr  <= i_cmd_src;
                  dst_q      <= i_cmd_dst;
                  is_rd      <= (i_cmd_op == OP_RD);
                  state      <= RD;
                end
                OP_LDI: begin
                  o_rf_wr_en <= 1'b1;
                  o_rf_addr  <= i_cmd_dst;
                  o_rf_wdata <= i_cmd_imm[DATA_WIDTH-1:0];
                  o_done     <= 1'b1;
                  state      <= WR;
                end
                default: begin
                  o_rf_wr_en <= 1'b1;
                  o_rf_addr  <= pair_hi;
                  o_rf_wdata <= i_cmd_imm[2*DATA_WIDTH-1:DATA_WIDTH];
                  dst_q      <= pair_lo;
                  imm_q      <= i_cmd_imm[DATA_WIDTH-1:0];
                  state      <= WR_HI;
                end
              endcase
            end
          end else begin
            o_cmd_ready <= 1'b1;
          end
        end
        RD: begin
          state <= RWAIT;
        end
        RWAIT: begin
          o_done <= 1'b1;
          if (is_rd) begin
            o_rsp_valid <= 1'b1;
            o_rsp_data  <= i_rf_rdata;
            state       <= RSP;
          end else begin
            o_rf_wr_en <= 1'b1;
            o_rf_addr  <= dst_q;
            o_rf_wdata <= i_rf_rdata;
            state      <= WR;
          end
        end
        WR_HI: begin
          o_rf_wr_en <= 1'b1;
          o_rf_addr  <= dst_q;
          o_rf_wdata <= imm_q;
          o_done     <= 1'b1;
          state      <= WR_LO;
        end
        WR, WR_LO: begin
          o_cmd_ready <= 1'b1;
          state       <= IDLE;
        end
        RSP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            o_cmd_ready <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_xfer_ctrl.sv
// tb_reg_xfer_ctrl: directed checks for reg_xfer_ctrl.
// Includes a registered-read register file model.
module tb_reg_xfer_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_dst;
  logic [2:0]  cmd_src;
  logic [15:0] cmd_imm;
  logic        rf_wr_en;
  logic        rf_rd_en;
  logic [2:0]  rf_addr;
  logic [7:0]  rf_wdata;
  logic [7:0]  rf_rdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic        done;
  logic        err;

  logic [7:0]  rf [8];
  logic        both_seen = 1'b0;
  int          total = 0;
  int          pass = 0;
  int          fail = 0;

  reg_xfer_ctrl dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_cmd_op    (cmd_op),
    .i_cmd_dst   (cmd_dst),
    .i_cmd_src   (cmd_src),
    .i_cmd_imm   (cmd_imm),
    .o_rf_wr_en  (rf_wr_en),
    .o_rf_rd_en  (rf_rd_en),
    .o_rf_addr   (rf_addr),
    .o_rf_wdata  (rf_wdata),
    .i_rf_rdata  (rf_rdata),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_data  (rsp_data),
    .o_done      (done),
    .o_err       (err)
  );

  always #5 clk = ~clk;

  // Register file model: one-cycle registered read
  always @(posedge clk) begin
    if (rf_rd_en) rf_rdata <= rf[rf_addr];
  end

  // Watch for concurrent read and write strobes
  always @(negedge clk) begin
    if (rf_rd_en && rf_wr_en) both_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    assert (obs === exp) pass++;
    else begin
      fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [1:0] op, input logic [2:0] dst,
                     input logic [2:0] src, input logic [15:0] imm);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_dst   = dst;
    cmd_src   = src;
    cmd_imm   = imm;
  endtask

  task automatic chk_strobes(input string tag, input logic wr,
                             input logic rd, input logic dn,
                             input logic er, input logic rdy);
    chk({tag, "_wr"}, 16'(rf_wr_en), 16'(wr));
    chk({tag, "_rd"}, 16'(rf_rd_en), 16'(rd));
    chk({tag, "_done"}, 16'(done), 16'(dn));
    chk({tag, "_err"}, 16'(err), 16'(er));
    chk({tag, "_rdy"}, 16'(cmd_ready), 16'(rdy));
  endtask

  task automatic chk_illegal(input string tag);
    step();
    cmd_valid = 1'b0;
    chk_strobes({tag, "_e0"}, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    chk_strobes({tag, "_e1"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = 8'(i);
    rf[2] = 8'h3C;
    rf[4] = 8'h81;
    rf_rdata  = 8'h00;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_dst   = 3'd0;
    cmd_src   = 3'd0;
    cmd_imm   = 16'h0;
    rsp_ready = 1'b0;

    step();
    step();
    chk_strobes("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_addr", 16'(rf_addr), 16'h0);
    chk("rst_rspv", 16'(rsp_valid), 16'h0);
    rst_n = 1'b1;
    step();
    chk("rel_rdy", 16'(cmd_ready), 16'h1);

    // LDI A <- 0x5A
    cmd(2'd1, 3'd7, 3'd0, 16'h005A);
    step();
    cmd_valid = 1'b0;
    chk_strobes("ldi_e0", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("ldi_addr", 16'(rf_addr), 16'h7);
    chk("ldi_wdata", 16'(rf_wdata), 16'h5A);
    step();
    chk_strobes("ldi_e1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // LDI16 DE <- 0xBEEF
    cmd(2'd2, 3'd1, 3'd0, 16'hBEEF);
    step();
    cmd_valid = 1'b0;
    chk_strobes("l16_e0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("l16_hi_addr", 16'(rf_addr), 16'h2);
    chk("l16_hi_data", 16'(rf_wdata), 16'hBE);
    step();
    chk_strobes("l16_e1", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("l16_lo_addr", 16'(rf_addr), 16'h3);
    chk("l16_lo_data", 16'(rf_wdata), 16'hEF);
    step();
    chk_strobes("l16_e2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // MOV L <- D
    cmd(2'd0, 3'd5, 3'd2, 16'h0);
    step();
    cmd_valid = 1'b0;
    cmd_dst   = 3'd1;
    chk_strobes("mov_e0", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("mov_rd_addr", 16'(rf_addr), 16'h2);
    step();
    chk_strobes("mov_e1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk_strobes("mov_e2", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("mov_wr_addr", 16'(rf_addr), 16'h5);
    chk("mov_wr_data", 16'(rf_wdata), 16'h3C);
    step();
    chk_strobes("mov_e3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // RD H with response stalled for 3 cycles
    cmd(2'd3, 3'd0, 3'd4, 16'h0);
    step();
    cmd_valid = 1'b0;
    chk_strobes("rd_e0", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rd_addr", 16'(rf_addr), 16'h4);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rd_e1_rspv", 16'(rsp_valid), 16'h0);
    step();
    chk_strobes("rd_e2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("rd_e2_rspv", 16'(rsp_valid), 16'h1);
    chk("rd_e2_data", 16'(rsp_data), 16'h81);
    step();
    chk("rd_e3_rspv", 16'(rsp_valid), 16'h1);
    chk("rd_e3_data", 16'(rsp_data), 16'h81);
    chk("rd_e3_done", 16'(done), 16'h0);
    step();
    chk("rd_e4_rspv", 16'(rsp_valid), 16'h1);
    chk("rd_e4_data", 16'(rsp_data), 16'h81);
    chk("rd_e4_rdy", 16'(cmd_ready), 16'h0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rd_hs_rspv", 16'(rsp_valid), 16'h0);
    chk("rd_hs_rdy", 16'(cmd_ready), 16'h1);

    // Illegal commands
    cmd(2'd1, 3'd6, 3'd0, 16'h00AA);
    chk_illegal("ill_ldi");
    cmd(2'd2, 3'd3, 3'd0, 16'h1234);
    chk_illegal("ill_l16");
    cmd(2'd0, 3'd1, 3'd6, 16'h0);
    chk_illegal("ill_mov");
    cmd(2'd3, 3'd0, 3'd6, 16'h0);
    chk_illegal("ill_rd");

    // Back-to-back LDI with valid held high
    cmd(2'd1, 3'd0, 3'd0, 16'h0011);
    step();
    cmd(2'd1, 3'd1, 3'd0, 16'h0022);
    chk("b2b_0_addr", 16'(rf_addr), 16'h0);
    chk("b2b_0_data", 16'(rf_wdata), 16'h11);
    step();
    chk_strobes("b2b_gap", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("b2b_hold_addr", 16'(rf_addr), 16'h0);
    chk("b2b_hold_data", 16'(rf_wdata), 16'h11);
    step();
    cmd_valid = 1'b0;
    chk_strobes("b2b_1", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("b2b_1_addr", 16'(rf_addr), 16'h1);
    chk("b2b_1_data", 16'(rf_wdata), 16'h22);
    step();

    // Reset during the low-byte write of LDI16 HL
    cmd(2'd2, 3'd2, 3'd0, 16'h1234);
    step();
    cmd_valid = 1'b0;
    chk("mid_hi_addr", 16'(rf_addr), 16'h4);
    step();
    chk("mid_lo_wr", 16'(rf_wr_en), 16'h1);
    chk("mid_lo_addr", 16'(rf_addr), 16'h5);
    #2;
    rst_n = 1'b0;
    #1;
    chk_strobes("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mid_rst_addr", 16'(rf_addr), 16'h0);
    chk("mid_rst_data", 16'(rf_wdata), 16'h0);
    #1;
    rst_n = 1'b1;
    step();
    chk("mid_rel_rdy", 16'(cmd_ready), 16'h1);
    cmd(2'd1, 3'd3, 3'd0, 16'h0077);
    step();
    cmd_valid = 1'b0;
    chk_strobes("post_ldi", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("post_addr", 16'(rf_addr), 16'h3);
    chk("post_data", 16'(rf_wdata), 16'h77);
    step();
    chk("post_rdy", 16'(cmd_ready), 16'h1);

    chk("no_concurrent", 16'(both_seen), 16'h0);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
